prog_sequencer: RTL and testbench

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_pkg.sv | 16 +
 rtl/branch_lut.sv | 37 +++
 rtl/prog_sequencer.sv | 134 +++++++++++++
 tb/tb_prog_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// Shared types and parameter defaults for the program sequencer.
package prog_pkg;

  localparam int unsigned PC_W_DEFAULT      = 12;
  localparam int unsigned LBL_W_DEFAULT     = 8;
  localparam int unsigned LUT_DEPTH_DEFAULT = 32;
  localparam int unsigned HALT_PC_DEFAULT   = 2000;
  localparam int unsigned CNT_W_DEFAULT     = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

endpackage : prog_pkg

// File: rtl/branch_lut.sv
// Branch-target table: synchronous write, combinational read, cleared by reset.
module branch_lut #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned DW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Clear every entry on reset; otherwise write only in-range addresses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (32'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational lookup; out-of-range addresses read as zero.
  always_comb begin
    rdata_o = '0;
    if (32'(raddr_i) < DEPTH) begin
      rdata_o = mem_q[raddr_i];
    end
  end

endmodule : branch_lut

// File: rtl/prog_sequencer.sv
// Program-counter sequencer with branch table, halt detection and perf counters.
module prog_sequencer
  import prog_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEFAULT,
  parameter int unsigned LBL_W     = LBL_W_DEFAULT,
  parameter int unsigned LUT_DEPTH = LUT_DEPTH_DEFAULT,
  parameter int unsigned HALT_PC   = HALT_PC_DEFAULT,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT,
  localparam int unsigned LUT_AW   = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              branch,
  input  logic              zero,
  input  logic [LBL_W-1:0]  label,
  input  logic              halt_req,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              pc_valid,
  output logic              done,
  output logic              lut_err,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instr_count
);

  seq_state_t       state_q;
  logic [PC_W-1:0]  pc_q;
  logic             done_q;
  logic             lut_err_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;

  logic [PC_W-1:0]  lut_rdata;
  logic             lut_we_ok;
  logic             at_halt;
  logic             lbl_ok;
  logic             taken;
  logic [PC_W-1:0]  pc_d;
  logic             lut_err_d;

  assign lut_we_ok = lut_we && (state_q != S_RUN);

  branch_lut #(
    .DEPTH (LUT_DEPTH),
    .AW    (LUT_AW),
    .DW    (PC_W)
  ) u_lut (
    .clk     (clk),
    .reset   (reset),
    .we_i    (lut_we_ok),
    .waddr_i (lut_waddr),
    .wdata_i (lut_wdata),
    .raddr_i (LUT_AW'(label)),
    .rdata_o (lut_rdata)
  );

  // Retire qualification and next-PC selection for the current instruction.
  always_comb begin
    at_halt   = (pc_q == PC_W'(HALT_PC));
    pc_valid  = (state_q == S_RUN) && !stall && !at_halt;
    taken     = branch && zero;
    lbl_ok    = (32'(label) < LUT_DEPTH);
    pc_d      = PC_W'(pc_q + PC_W'(1));
    lut_err_d = 1'b0;
    if (taken) begin
      if (lbl_ok) begin
        pc_d = lut_rdata;
      end else begin
        lut_err_d = 1'b1;
      end
    end
  end

  // Sequencer FSM with PC, sticky flags and saturating counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      done_q    <= 1'b0;
      lut_err_q <= 1'b0;
      cycle_q   <= '0;
      instr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_RUN;
            pc_q      <= '0;
            done_q    <= 1'b0;
            lut_err_q <= 1'b0;
            cycle_q   <= '0;
            instr_q   <= '0;
          end
        end
        S_RUN: begin
          if (!(&cycle_q)) begin
            cycle_q <= cycle_q + CNT_W'(1);
          end
          if (at_halt) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (!stall) begin
            if (!(&instr_q)) begin
              instr_q <= instr_q + CNT_W'(1);
            end
            pc_q <= pc_d;
            if (lut_err_d) begin
              lut_err_q <= 1'b1;
            end
            if (halt_req) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign done        = done_q;
  assign lut_err     = lut_err_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

endmodule : prog_sequencer

// File: tb/tb_prog_sequencer.sv
// Directed self-checking bench for prog_sequencer.
module tb_prog_sequencer;

  localparam int unsigned PC_W   = 12;
  localparam int unsigned LBL_W  = 8;
  localparam int unsigned LUT_AW = 5;
  localparam int unsigned CNT_W  = 32;

  logic              clk;
  logic              reset;
  logic              start;
  logic              stall;
  logic              branch;
  logic              zero;
  logic [LBL_W-1:0]  label;
  logic              halt_req;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   pc;
  logic              pc_valid;
  logic              done;
  logic              lut_err;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  instr_count;

  int checks = 0;
  int errors = 0;

  prog_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .branch      (branch),
    .zero        (zero),
    .label       (label),
    .halt_req    (halt_req),
    .lut_we      (lut_we),
    .lut_waddr   (lut_waddr),
    .lut_wdata   (lut_wdata),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .done        (done),
    .lut_err     (lut_err),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; branch = 0; zero = 0; label = '0;
    halt_req = 0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    tick(); tick();
    checks++; if (pc !== 12'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", pc); end
    checks++; if (done !== 1'b0 || lut_err !== 1'b0) begin errors++; $display("FAIL reset_flags got done=%b err=%b exp 0/0", done, lut_err); end
    checks++; if (cycle_count !== 0 || instr_count !== 0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", cycle_count, instr_count); end
    reset = 1;
    tick();
    checks++; if (pc_valid !== 1'b0 || pc !== 12'd0) begin errors++; $display("FAIL idle_hold got valid=%b pc=%0d exp 0/0", pc_valid, pc); end
  endtask

  task automatic test_sequential();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (pc !== PC_W'(i) || pc_valid !== 1'b1) begin errors++; $display("FAIL seq_pc got pc=%0d valid=%b exp %0d/1", pc, pc_valid, i); end
      tick();
    end
    checks++; if (pc !== 12'd5 || instr_count !== 5 || cycle_count !== 5) begin errors++; $display("FAIL seq_after5 got pc=%0d ic=%0d cc=%0d exp 5/5/5", pc, instr_count, cycle_count); end
    start = 1; tick(); start = 0;
    checks++; if (pc !== 12'd6) begin errors++; $display("FAIL start_in_run got pc=%0d exp 6", pc); end
    halt_req = 1; tick(); halt_req = 0;
    checks++; if (pc !== 12'd7 || done !== 1'b1 || instr_count !== 7 || cycle_count !== 7) begin errors++; $display("FAIL halt_req got pc=%0d done=%b ic=%0d cc=%0d exp 7/1/7/7", pc, done, instr_count, cycle_count); end
    #1;
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL done_valid got %b exp 0", pc_valid); end
  endtask

  task automatic test_branch();
    lut_we = 1; lut_waddr = 5'd3; lut_wdata = 12'd40; tick(); lut_we = 0;
    start = 1; tick(); start = 0;
    checks++; if (pc !== 12'd0 || done !== 1'b0 || cycle_count !== 0) begin errors++; $display("FAIL restart got pc=%0d done=%b cc=%0d exp 0/0/0", pc, done, cycle_count); end
    tick(); tick();
    branch = 1; zero = 1; label = 8'd3; #1;
    checks++; if (pc !== 12'd2 || pc_valid !== 1'b1) begin errors++; $display("FAIL pre_branch got pc=%0d valid=%b exp 2/1", pc, pc_valid); end
    tick(); branch = 0; zero = 0;
    checks++; if (pc !== 12'd40) begin errors++; $display("FAIL branch_taken got %0d exp 40", pc); end
    halt_req = 1; tick(); halt_req = 0;
    checks++; if (pc !== 12'd41 || done !== 1'b1) begin errors++; $display("FAIL halt_after_branch got pc=%0d done=%b exp 41/1", pc, done); end
    start = 1; tick(); start = 0;
    tick(); tick();
    branch = 1; zero = 0; label = 8'd3; tick(); branch = 0;
    checks++; if (pc !== 12'd3 || instr_count !== 3) begin errors++; $display("FAIL branch_not_taken got pc=%0d ic=%0d exp 3/3", pc, instr_count); end
  endtask

  task automatic test_stall();
    repeat (4) tick();
    checks++; if (pc !== 12'd7 || instr_count !== 7 || cycle_count !== 7) begin errors++; $display("FAIL pre_stall got pc=%0d ic=%0d cc=%0d exp 7/7/7", pc, instr_count, cycle_count); end
    stall = 1; branch = 1; zero = 1; label = 8'd3; halt_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL stall_valid got %b exp 0", pc_valid); end
      tick();
    end
    checks++; if (pc !== 12'd7 || instr_count !== 7 || cycle_count !== 10 || done !== 1'b0) begin errors++; $display("FAIL stall_hold got pc=%0d ic=%0d cc=%0d done=%b exp 7/7/10/0", pc, instr_count, cycle_count, done); end
    clear_inputs();
  endtask

  task automatic test_lut_write_in_run();
    lut_we = 1; lut_waddr = 5'd3; lut_wdata = 12'd100; tick(); lut_we = 0;
    branch = 1; zero = 1; label = 8'd3; tick(); clear_inputs();
    checks++; if (pc !== 12'd40) begin errors++; $display("FAIL run_write_dropped got %0d exp 40", pc); end
  endtask

  task automatic test_lut_err();
    branch = 1; zero = 1; label = 8'd32; tick(); clear_inputs();
    checks++; if (pc !== 12'd41 || lut_err !== 1'b1) begin errors++; $display("FAIL lut_err got pc=%0d err=%b exp 41/1", pc, lut_err); end
    tick();
    checks++; if (pc !== 12'd42 || lut_err !== 1'b1) begin errors++; $display("FAIL lut_err_sticky got pc=%0d err=%b exp 42/1", pc, lut_err); end
  endtask

  task automatic test_halt_pc();
    halt_req = 1; tick(); halt_req = 0;
    lut_we = 1; lut_waddr = 5'd0; lut_wdata = 12'd1999; tick(); lut_we = 0;
    checks++; if (pc !== 12'd43 || lut_err !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL done_frozen got pc=%0d err=%b done=%b exp 43/1/1", pc, lut_err, done); end
    start = 1; tick(); start = 0;
    checks++; if (pc !== 12'd0 || lut_err !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL restart_clear got pc=%0d err=%b done=%b exp 0/0/0", pc, lut_err, done); end
    branch = 1; zero = 1; label = 8'd0; tick(); clear_inputs(); #1;
    checks++; if (pc !== 12'd1999 || pc_valid !== 1'b1) begin errors++; $display("FAIL jump_1999 got pc=%0d valid=%b exp 1999/1", pc, pc_valid); end
    tick();
    checks++; if (pc !== 12'd2000 || done !== 1'b0 || instr_count !== 2 || cycle_count !== 2) begin errors++; $display("FAIL at_halt got pc=%0d done=%b ic=%0d cc=%0d exp 2000/0/2/2", pc, done, instr_count, cycle_count); end
    stall = 1; branch = 1; zero = 1; label = 8'd3; #1;
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got %b exp 0", pc_valid); end
    tick();
    checks++; if (pc !== 12'd2000 || done !== 1'b1 || instr_count !== 2 || cycle_count !== 3) begin errors++; $display("FAIL halt_done got pc=%0d done=%b ic=%0d cc=%0d exp 2000/1/2/3", pc, done, instr_count, cycle_count); end
    clear_inputs(); tick();
    checks++; if (pc !== 12'd2000 || cycle_count !== 3 || done !== 1'b1) begin errors++; $display("FAIL done_hold got pc=%0d cc=%0d done=%b exp 2000/3/1", pc, cycle_count, done); end
    start = 1; tick(); start = 0;
    checks++; if (pc !== 12'd0 || done !== 1'b0 || cycle_count !== 0 || instr_count !== 0) begin errors++; $display("FAIL restart_from_done got pc=%0d done=%b cc=%0d ic=%0d exp 0/0/0/0", pc, done, cycle_count, instr_count); end
  endtask

  task automatic test_reset_mid_run();
    tick(); tick();
    reset = 0; start = 1; lut_we = 1; lut_waddr = 5'd3; lut_wdata = 12'd77;
    branch = 1; zero = 1; label = 8'd0;
    tick();
    checks++; if (pc !== 12'd0 || done !== 1'b0 || lut_err !== 1'b0 || cycle_count !== 0 || instr_count !== 0 || pc_valid !== 1'b0) begin errors++; $display("FAIL mid_reset got pc=%0d done=%b err=%b cc=%0d ic=%0d valid=%b exp all 0", pc, done, lut_err, cycle_count, instr_count, pc_valid); end
    clear_inputs(); reset = 1; tick();
    checks++; if (pc !== 12'd0 || pc_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got pc=%0d valid=%b exp 0/0", pc, pc_valid); end
    start = 1; tick(); start = 0;
    branch = 1; zero = 1; label = 8'd3; tick(); clear_inputs();
    checks++; if (pc !== 12'd0) begin errors++; $display("FAIL table_cleared got %0d exp 0", pc); end
    tick();
    checks++; if (pc !== 12'd1 || instr_count !== 2) begin errors++; $display("FAIL post_reset_run got pc=%0d ic=%0d exp 1/2", pc, instr_count); end
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_lut_write_in_run();
    test_lut_err();
    test_halt_pc();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_prog_sequencer
